// File: rtl/serial_tx_pkg.sv
// Shared types and constants for the serial "101" pattern transmitter.
// The PARITY state exists only when TX_PARITY_EN is defined.
package serial_tx_pkg;

    localparam logic [2:0] DETECT_PATTERN = 3'b101;

`ifdef TX_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} tx_state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT} tx_state_t;
`endif

    function automatic int len_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/serial_pattern_tx_if.sv
// Parallel word load channel (valid/ready) feeding serial_pattern_tx.
interface serial_pattern_tx_if
    import serial_tx_pkg::*;
#(
    parameter int WIDTH = 8
);
    localparam int LEN_W = len_width(WIDTH);

    logic [WIDTH-1:0] load_data;
    logic [LEN_W-1:0] load_len;
    logic             load_valid;
    logic             load_ready;

    modport master (
        output load_data,
        output load_len,
        output load_valid,
        input  load_ready
    );

    modport slave (
        input  load_data,
        input  load_len,
        input  load_valid,
        output load_ready
    );

endinterface

// File: rtl/seq101_tracker.sv
// Golden overlapping "101" detector: flags the completing bit and keeps a
// saturating detection count. Also usable standalone as a scoreboard.
module seq101_tracker
    import serial_tx_pkg::*;
#(
    parameter int CNT_W = 8
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic             bit_valid,
    input  logic             bit_in,
    input  logic             det_clr,
    output logic             expect_det,
    output logic [CNT_W-1:0] det_count
);

    logic [1:0] hist;

    assign expect_det = bit_valid && ({hist, bit_in} == DETECT_PATTERN);

    // Any cycle without a stream bit breaks the pattern history.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist <= '0;
        end else if (bit_valid) begin
            hist <= {hist[0], bit_in};
        end else begin
            hist <= '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            det_count <= '0;
        end else if (det_clr) begin
            det_count <= '0;
        end else if (expect_det && (det_count != {CNT_W{1'b1}})) begin
            det_count <= det_count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/serial_pattern_tx.sv
// Serial MSB-first bit-stream transmitter with a built-in golden "101" tracker.
// Define TX_PARITY_EN to append an even-parity bit after each word.
module serial_pattern_tx
    import serial_tx_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
)
(
    input  logic                clk,
    input  logic                reset,
    serial_pattern_tx_if.slave  load,
    input  logic                det_clr,
    output logic                out,
    output logic                out_valid,
    output logic                expect_det,
    output logic [CNT_W-1:0]    det_count,
    output logic                busy,
    output logic                done
);

    localparam int LEN_W = len_width(WIDTH);

    tx_state_t        state, state_next;
    logic [WIDTH-1:0] shreg, shreg_next;
    logic [LEN_W-1:0] rem, rem_next;
    logic             out_next;
    logic [LEN_W-1:0] eff_len;
    logic [WIDTH-1:0] aligned;
    logic             last;
    logic             ready;
    logic             accept;
`ifdef TX_PARITY_EN
    logic             par, par_next;
`endif

    assign eff_len = (load.load_len > LEN_W'(WIDTH)) ? LEN_W'(WIDTH) : load.load_len;
    // Left-align the used bits so the first bit to send sits at the MSB.
    assign aligned = load.load_data << (LEN_W'(WIDTH) - eff_len);

`ifdef TX_PARITY_EN
    assign last = (state == PARITY);
`else
    assign last = (state == SHIFT) && (rem == LEN_W'(1));
`endif

    assign ready           = (state == IDLE) || last;
    assign load.load_ready = ready;
    assign accept          = load.load_valid && ready;

    assign out_valid = (state != IDLE);
    assign busy      = (state != IDLE);
    assign done      = last;

    // Next-state and datapath: a load wins, otherwise keep shifting or go idle.
    always_comb begin
        state_next = state;
        out_next   = 1'b0;
        shreg_next = shreg;
        rem_next   = rem;
`ifdef TX_PARITY_EN
        par_next   = par;
`endif
        if (accept && (eff_len != '0)) begin
            state_next = SHIFT;
            out_next   = aligned[WIDTH-1];
            shreg_next = aligned << 1;
            rem_next   = eff_len;
`ifdef TX_PARITY_EN
            par_next   = ^aligned;
`endif
        end else if ((state == IDLE) || last) begin
            state_next = IDLE;
            shreg_next = '0;
            rem_next   = '0;
        end else begin
            out_next   = shreg[WIDTH-1];
            shreg_next = shreg << 1;
            rem_next   = rem - LEN_W'(1);
`ifdef TX_PARITY_EN
            if (rem == LEN_W'(1)) begin
                state_next = PARITY;
                out_next   = par;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            out   <= 1'b0;
            shreg <= '0;
            rem   <= '0;
`ifdef TX_PARITY_EN
            par   <= 1'b0;
`endif
        end else begin
            state <= state_next;
            out   <= out_next;
            shreg <= shreg_next;
            rem   <= rem_next;
`ifdef TX_PARITY_EN
            par   <= par_next;
`endif
        end
    end

    seq101_tracker #(
        .CNT_W (CNT_W)
    ) u_tracker (
        .clk        (clk),
        .reset      (reset),
        .bit_valid  (out_valid),
        .bit_in     (out),
        .det_clr    (det_clr),
        .expect_det (expect_det),
        .det_count  (det_count)
    );

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Table-driven bench for serial_pattern_tx (default CNT_W plus a CNT_W=2 copy).
module tb_serial_pattern_tx;
    import serial_tx_pkg::*;

    localparam int WIDTH = 8;
    localparam int LEN_W = len_width(WIDTH);

    typedef struct {
        logic [7:0]       data;
        logic [LEN_W-1:0] len;
        int               nbits;
        logic [7:0]       bits;
        logic [7:0]       dets;
        logic [7:0]       count;
    } vec_t;

    logic             clk = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] ld_data;
    logic [LEN_W-1:0] ld_len;
    logic             ld_valid;
    logic             det_clr;

    logic       out_a, out_valid_a, expect_det_a, busy_a, done_a;
    logic [7:0] det_count_a;
    logic       out_b, out_valid_b, expect_det_b, busy_b, done_b;
    logic [1:0] det_count_b;

    int checks   = 0;
    int failures = 0;

    vec_t tbl [7];

    serial_pattern_tx_if #(.WIDTH(WIDTH)) bus_a ();
    serial_pattern_tx_if #(.WIDTH(WIDTH)) bus_b ();

    assign bus_a.load_data  = ld_data;
    assign bus_a.load_len   = ld_len;
    assign bus_a.load_valid = ld_valid;
    assign bus_b.load_data  = ld_data;
    assign bus_b.load_len   = ld_len;
    assign bus_b.load_valid = ld_valid;

    serial_pattern_tx #(.WIDTH(WIDTH), .CNT_W(8)) dut_a (
        .clk        (clk),
        .reset      (reset),
        .load       (bus_a.slave),
        .det_clr    (det_clr),
        .out        (out_a),
        .out_valid  (out_valid_a),
        .expect_det (expect_det_a),
        .det_count  (det_count_a),
        .busy       (busy_a),
        .done       (done_a)
    );

    serial_pattern_tx #(.WIDTH(WIDTH), .CNT_W(2)) dut_b (
        .clk        (clk),
        .reset      (reset),
        .load       (bus_b.slave),
        .det_clr    (det_clr),
        .out        (out_b),
        .out_valid  (out_valid_b),
        .expect_det (expect_det_b),
        .det_count  (det_count_b),
        .busy       (busy_b),
        .done       (done_b)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Loads one word from idle and checks every bit cycle plus the final count.
    task automatic applyStimulus(input vec_t v, input int idx, input bit do_clr);
        if (do_clr) begin
            det_clr = 1'b1;
            tick();
            det_clr = 1'b0;
        end
        ld_data  = v.data;
        ld_len   = v.len;
        ld_valid = 1'b1;
        tick();
        ld_valid = 1'b0;
        ld_data  = '1;
        ld_len   = '0;
        if (v.nbits == 0) begin
            for (int k = 0; k < 3; k++) begin
                checkOutput($sformatf("v%0d_idle_valid%0d", idx, k), 32'(out_valid_a), 32'd0);
                checkOutput($sformatf("v%0d_idle_ready%0d", idx, k), 32'(bus_a.load_ready), 32'd1);
                tick();
            end
        end else begin
            for (int k = 0; k < v.nbits; k++) begin
                checkOutput($sformatf("v%0d_out%0d", idx, k), 32'(out_a), 32'(v.bits[7-k]));
                checkOutput($sformatf("v%0d_valid%0d", idx, k), 32'(out_valid_a), 32'd1);
                checkOutput($sformatf("v%0d_det%0d", idx, k), 32'(expect_det_a), 32'(v.dets[7-k]));
                checkOutput($sformatf("v%0d_done%0d", idx, k), 32'(done_a), 32'(k == v.nbits - 1));
                checkOutput($sformatf("v%0d_ready%0d", idx, k), 32'(bus_a.load_ready), 32'(k == v.nbits - 1));
                checkOutput($sformatf("v%0d_busy%0d", idx, k), 32'(busy_a), 32'd1);
                tick();
            end
        end
        checkOutput($sformatf("v%0d_end_valid", idx), 32'(out_valid_a), 32'd0);
        checkOutput($sformatf("v%0d_count", idx), 32'(det_count_a), 32'(v.count));
    endtask

    initial begin
        vec_t sat0;
        vec_t sat1;

        tbl[0] = '{8'b0000_0101, 4'd3,  3, 8'b1010_0000, 8'b0010_0000, 8'd1};
        tbl[1] = '{8'b0001_0101, 4'd5,  5, 8'b1010_1000, 8'b0010_1000, 8'd2};
        tbl[2] = '{8'b1111_1111, 4'd0,  0, 8'b0000_0000, 8'b0000_0000, 8'd0};
        tbl[3] = '{8'b1101_0110, 4'd15, 8, 8'b1101_0110, 8'b0001_0100, 8'd2};
        tbl[4] = '{8'b1010_0101, 4'd8,  8, 8'b1010_0101, 8'b0010_0001, 8'd2};
        tbl[5] = '{8'b0000_0010, 4'd2,  2, 8'b1000_0000, 8'b0000_0000, 8'd0};
        tbl[6] = '{8'b0000_0000, 4'd8,  8, 8'b0000_0000, 8'b0000_0000, 8'd0};
        sat0   = '{8'b1010_1010, 4'd8,  8, 8'b1010_1010, 8'b0010_1010, 8'd3};
        sat1   = '{8'b0001_0101, 4'd5,  5, 8'b1010_1000, 8'b0010_1000, 8'd5};

        reset    = 1'b0;
        ld_data  = '0;
        ld_len   = '0;
        ld_valid = 1'b0;
        det_clr  = 1'b0;
        tick();
        tick();
        checkOutput("rst_out", 32'(out_a), 32'd0);
        checkOutput("rst_valid", 32'(out_valid_a), 32'd0);
        checkOutput("rst_det", 32'(expect_det_a), 32'd0);
        checkOutput("rst_count", 32'(det_count_a), 32'd0);
        checkOutput("rst_busy", 32'(busy_a), 32'd0);
        checkOutput("rst_done", 32'(done_a), 32'd0);
        reset = 1'b1;
        tick();
        checkOutput("rel_ready", 32'(bus_a.load_ready), 32'd1);

`ifdef TX_PARITY_EN
        ld_data  = 8'b0000_0101;
        ld_len   = 4'd3;
        ld_valid = 1'b1;
        tick();
        ld_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("par_out%0d", k), 32'(out_a), 32'(k % 2 == 0));
            checkOutput($sformatf("par_valid%0d", k), 32'(out_valid_a), 32'd1);
            checkOutput($sformatf("par_done%0d", k), 32'(done_a), 32'(k == 3));
            tick();
        end
        checkOutput("par_end_valid", 32'(out_valid_a), 32'd0);
`else
        for (int i = 0; i < 7; i++) begin
            applyStimulus(tbl[i], i, 1'b1);
        end

        // Back-to-back words accepted on the last-bit edge keep the history.
        det_clr = 1'b1;
        tick();
        det_clr  = 1'b0;
        ld_data  = 8'b0000_0010;
        ld_len   = 4'd2;
        ld_valid = 1'b1;
        tick();
        ld_valid = 1'b0;
        checkOutput("xw_bit0", 32'(out_a), 32'd1);
        tick();
        checkOutput("xw_bit1", 32'(out_a), 32'd0);
        checkOutput("xw_ready_last", 32'(bus_a.load_ready), 32'd1);
        ld_data  = 8'b0000_0001;
        ld_len   = 4'd1;
        ld_valid = 1'b1;
        tick();
        ld_valid = 1'b0;
        checkOutput("xw_w2_valid", 32'(out_valid_a), 32'd1);
        checkOutput("xw_w2_out", 32'(out_a), 32'd1);
        checkOutput("xw_w2_det", 32'(expect_det_a), 32'd1);
        checkOutput("xw_w2_done", 32'(done_a), 32'd1);
        tick();
        checkOutput("xw_end_valid", 32'(out_valid_a), 32'd0);
        checkOutput("xw_count", 32'(det_count_a), 32'd1);

        // Same words with one idle cycle in between: no detection.
        det_clr = 1'b1;
        tick();
        det_clr  = 1'b0;
        ld_data  = 8'b0000_0010;
        ld_len   = 4'd2;
        ld_valid = 1'b1;
        tick();
        ld_valid = 1'b0;
        tick();
        tick();
        checkOutput("gap_idle_valid", 32'(out_valid_a), 32'd0);
        ld_data  = 8'b0000_0001;
        ld_len   = 4'd1;
        ld_valid = 1'b1;
        tick();
        ld_valid = 1'b0;
        checkOutput("gap_w2_out", 32'(out_a), 32'd1);
        checkOutput("gap_w2_det", 32'(expect_det_a), 32'd0);
        tick();
        checkOutput("gap_count", 32'(det_count_a), 32'd0);

        // det_clr wins over the increment in the same cycle.
        ld_data  = 8'b0000_0101;
        ld_len   = 4'd3;
        ld_valid = 1'b1;
        tick();
        ld_valid = 1'b0;
        tick();
        tick();
        checkOutput("clr_det", 32'(expect_det_a), 32'd1);
        det_clr = 1'b1;
        tick();
        det_clr = 1'b0;
        checkOutput("clr_count", 32'(det_count_a), 32'd0);

        // Five detections: 8-bit counter reaches 5, 2-bit counter holds 3.
        applyStimulus(sat0, 100, 1'b1);
        applyStimulus(sat1, 101, 1'b0);
        checkOutput("sat_count_b", 32'(det_count_b), 32'd3);
        checkOutput("sat_b_valid", 32'(out_valid_b), 32'd0);
        checkOutput("sat_b_out", 32'(out_b), 32'd0);
        checkOutput("sat_b_det", 32'(expect_det_b), 32'd0);
        checkOutput("sat_b_busy", 32'(busy_b), 32'd0);
        checkOutput("sat_b_done", 32'(done_b), 32'd0);
        checkOutput("sat_b_ready", 32'(bus_b.load_ready), 32'd1);

        // Reset asserted mid-word clears outputs without a clock edge.
        ld_data  = 8'hFF;
        ld_len   = 4'd8;
        ld_valid = 1'b1;
        tick();
        ld_valid = 1'b0;
        tick();
        checkOutput("mid_pre_out", 32'(out_a), 32'd1);
        #3;
        reset = 1'b0;
        #1;
        checkOutput("mid_out", 32'(out_a), 32'd0);
        checkOutput("mid_valid", 32'(out_valid_a), 32'd0);
        checkOutput("mid_count", 32'(det_count_a), 32'd0);
        tick();
        reset = 1'b1;
        checkOutput("mid_rel_ready", 32'(bus_a.load_ready), 32'd1);
        checkOutput("mid_rel_valid", 32'(out_valid_a), 32'd0);
        tick();
        applyStimulus(tbl[0], 200, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
